// File: rtl/cpu_control_fsm.sv
// ============================================================================
// Module      : cpu_control_fsm
// Description : Multi-cycle FETCH/DECODE/EXEC/MEM control sequencer for the
//               16-bit CPU, with memory timeout fault and retire counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_control_fsm #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [22:0]      dec_ops,
  input  logic             flag_z,
  input  logic             flag_c,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             addr_sel,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             b_sel,
  output logic [2:0]       alu_op,
  output logic             reg_we,
  output logic [1:0]       wb_sel,
  output logic             flag_we,
  output logic             out_we,
  output logic             illegal_op,
  output logic             halted,
  output logic             fault,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] inst_count
);

  localparam logic [2:0] c_st_fetch  = 3'd0;
  localparam logic [2:0] c_st_decode = 3'd1;
  localparam logic [2:0] c_st_exec   = 3'd2;
  localparam logic [2:0] c_st_mem    = 3'd3;
  localparam logic [2:0] c_st_halt   = 3'd4;
  localparam logic [2:0] c_st_fault  = 3'd5;

  localparam int c_op_mov = 0,  c_op_addi = 1,  c_op_subi = 2,  c_op_lhi = 3;
  localparam int c_op_lli = 4,  c_op_ldr  = 5,  c_op_str  = 6,  c_op_add = 7;
  localparam int c_op_adc = 8,  c_op_sub  = 9,  c_op_sbb  = 10, c_op_cmp = 11;
  localparam int c_op_bcc = 12, c_op_bcs  = 13, c_op_bne  = 14, c_op_beq = 15;
  localparam int c_op_bal = 16, c_op_jmp  = 17, c_op_jall = 18, c_op_jalr = 19;
  localparam int c_op_jr  = 20, c_op_outr = 21, c_op_hlt  = 22;

  localparam int c_wait_w = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [c_wait_w-1:0] c_wait_last = c_wait_w'(MEM_TIMEOUT - 1);

  logic [2:0]          r_state, w_next;
  logic [c_wait_w-1:0] r_wait;
  logic [CNT_W-1:0]    r_cnt;

  logic       w_mem_req, w_mem_we, w_addr_sel, w_ir_we, w_pc_we, w_b_sel;
  logic [1:0] w_pc_sel, w_wb_sel;
  logic [2:0] w_alu_op;
  logic       w_reg_we, w_flag_we, w_out_we, w_illegal, w_retire;
  logic       w_onehot, w_wait_done, w_rel_take;

  assign w_onehot    = (dec_ops != '0) && ((dec_ops & (dec_ops - 23'd1)) == '0);
  assign w_wait_done = (r_wait == c_wait_last);
  assign w_rel_take  = (dec_ops[c_op_bcc] & ~flag_c) | (dec_ops[c_op_bcs] & flag_c) |
                       (dec_ops[c_op_bne] & ~flag_z) | (dec_ops[c_op_beq] & flag_z) |
                       dec_ops[c_op_bal] | dec_ops[c_op_jmp] | dec_ops[c_op_jall];

  always_comb begin
    w_next     = r_state;
    w_mem_req  = 1'b0;
    w_mem_we   = 1'b0;
    w_addr_sel = 1'b0;
    w_ir_we    = 1'b0;
    w_pc_we    = 1'b0;
    w_pc_sel   = 2'd0;
    w_b_sel    = 1'b0;
    w_alu_op   = 3'd0;
    w_reg_we   = 1'b0;
    w_wb_sel   = 2'd0;
    w_flag_we  = 1'b0;
    w_out_we   = 1'b0;
    w_illegal  = 1'b0;
    w_retire   = 1'b0;
    unique case (r_state)
      c_st_fetch: begin
        w_mem_req = 1'b1;
        if (mem_ready) begin
          w_ir_we = 1'b1;
          w_pc_we = 1'b1;
          w_next  = c_st_decode;
        end else if (w_wait_done) begin
          w_next = c_st_fault;
        end
      end
      c_st_decode: w_next = c_st_exec;
      c_st_exec: begin
        w_next   = c_st_fetch;
        w_retire = 1'b1;
        if (!w_onehot) begin
          w_illegal = 1'b1;
        end else begin
          if (dec_ops[c_op_add]) begin w_reg_we = 1'b1; w_flag_we = 1'b1; end
          if (dec_ops[c_op_adc]) begin w_alu_op = 3'd1; w_reg_we = 1'b1; w_flag_we = 1'b1; end
          if (dec_ops[c_op_sub]) begin w_alu_op = 3'd2; w_reg_we = 1'b1; w_flag_we = 1'b1; end
          if (dec_ops[c_op_sbb]) begin w_alu_op = 3'd3; w_reg_we = 1'b1; w_flag_we = 1'b1; end
          if (dec_ops[c_op_addi]) begin w_b_sel = 1'b1; w_reg_we = 1'b1; w_flag_we = 1'b1; end
          if (dec_ops[c_op_subi]) begin
            w_alu_op = 3'd2; w_b_sel = 1'b1; w_reg_we = 1'b1; w_flag_we = 1'b1;
          end
          if (dec_ops[c_op_cmp]) begin w_alu_op = 3'd2; w_flag_we = 1'b1; end
          if (dec_ops[c_op_mov]) begin w_alu_op = 3'd4; w_reg_we = 1'b1; end
          if (dec_ops[c_op_lhi]) begin w_alu_op = 3'd5; w_b_sel = 1'b1; w_reg_we = 1'b1; end
          if (dec_ops[c_op_lli]) begin w_alu_op = 3'd6; w_b_sel = 1'b1; w_reg_we = 1'b1; end
          // Loads/stores compute their address here and retire only in MEM.
          if (dec_ops[c_op_ldr] | dec_ops[c_op_str]) begin
            w_b_sel  = 1'b1;
            w_retire = 1'b0;
            w_next   = c_st_mem;
          end
          if (w_rel_take) begin w_pc_we = 1'b1; w_pc_sel = 2'd1; end
          if (dec_ops[c_op_jalr] | dec_ops[c_op_jr]) begin w_pc_we = 1'b1; w_pc_sel = 2'd2; end
          if (dec_ops[c_op_jall] | dec_ops[c_op_jalr]) begin w_reg_we = 1'b1; w_wb_sel = 2'd2; end
          if (dec_ops[c_op_outr]) w_out_we = 1'b1;
          if (dec_ops[c_op_hlt]) w_next = c_st_halt;
        end
      end
      c_st_mem: begin
        w_mem_req  = 1'b1;
        w_addr_sel = 1'b1;
        w_mem_we   = dec_ops[c_op_str];
        w_b_sel    = 1'b1;
        if (mem_ready) begin
          w_reg_we = dec_ops[c_op_ldr];
          w_wb_sel = dec_ops[c_op_ldr] ? 2'd1 : 2'd0;
          w_retire = 1'b1;
          w_next   = c_st_fetch;
        end else if (w_wait_done) begin
          w_next = c_st_fault;
        end
      end
      c_st_halt:  w_next = c_st_halt;
      c_st_fault: w_next = c_st_fault;
      default:    w_next = c_st_fault;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_st_fetch;
      r_wait  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_retire) r_cnt <= r_cnt + CNT_W'(1);
      // Counts consecutive unanswered request cycles; any state change restarts it.
      if (w_next != r_state || mem_ready) r_wait <= '0;
      else if (r_state == c_st_fetch || r_state == c_st_mem) r_wait <= r_wait + 1'b1;
    end
  end

  assign mem_req    = w_mem_req  & ~rst;
  assign mem_we     = w_mem_we   & ~rst;
  assign addr_sel   = w_addr_sel & ~rst;
  assign ir_we      = w_ir_we    & ~rst;
  assign pc_we      = w_pc_we    & ~rst;
  assign pc_sel     = rst ? 2'd0 : w_pc_sel;
  assign b_sel      = w_b_sel    & ~rst;
  assign alu_op     = rst ? 3'd0 : w_alu_op;
  assign reg_we     = w_reg_we   & ~rst;
  assign wb_sel     = rst ? 2'd0 : w_wb_sel;
  assign flag_we    = w_flag_we  & ~rst;
  assign out_we     = w_out_we   & ~rst;
  assign illegal_op = w_illegal  & ~rst;
  assign halted     = ~rst & ((r_state == c_st_halt) | (r_state == c_st_fault));
  assign fault      = ~rst & (r_state == c_st_fault);
  assign state      = r_state;
  assign inst_count = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_cpu_control_fsm.sv
// ============================================================================
// Module      : tb_cpu_control_fsm
// Description : Self-checking bench for cpu_control_fsm (vector table plus
//               hand-written multi-cycle sequences, scoreboard compare).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpu_control_fsm;

  typedef struct packed {
    logic [2:0]  st;
    logic        mem_req, mem_we, addr_sel, ir_we, pc_we;
    logic [1:0]  pc_sel;
    logic        b_sel;
    logic [2:0]  alu_op;
    logic        reg_we;
    logic [1:0]  wb_sel;
    logic        flag_we, out_we, illegal_op, halted, fault;
    logic [15:0] cnt;
  } obs_t;

  typedef struct {
    string       name;
    logic [22:0] ops;
    logic        z, c;
    logic        pc_we;
    logic [1:0]  pc_sel;
    logic        b_sel;
    logic [2:0]  alu;
    logic        reg_we;
    logic [1:0]  wb;
    logic        flag_we, out_we, ill;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [22:0] dec_ops;
  logic        flag_z, flag_c, mem_ready;
  logic        mem_req, mem_we, addr_sel, ir_we, pc_we, b_sel, reg_we;
  logic        flag_we, out_we, illegal_op, halted, fault;
  logic [1:0]  pc_sel, wb_sel;
  logic [2:0]  alu_op, state;
  logic [15:0] inst_count;

  obs_t        exp_q[$];
  string       name_q[$];
  vec_t        tbl[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] cnt_m;

  always #5 clk = ~clk;

  cpu_control_fsm #(.MEM_TIMEOUT(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .dec_ops(dec_ops), .flag_z(flag_z), .flag_c(flag_c),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel),
    .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .b_sel(b_sel), .alu_op(alu_op),
    .reg_we(reg_we), .wb_sel(wb_sel), .flag_we(flag_we), .out_we(out_we),
    .illegal_op(illegal_op), .halted(halted), .fault(fault), .state(state),
    .inst_count(inst_count)
  );

  function automatic logic [22:0] op(input int i);
    logic [22:0] one;
    one = 23'd1;
    return one << i;
  endfunction

  function automatic obs_t idle(input logic [2:0] st);
    obs_t o;
    o     = '0;
    o.st  = st;
    o.cnt = cnt_m;
    return o;
  endfunction

  function automatic vec_t mkv(input string nm, input logic [22:0] ops, input logic z, c,
                               input logic pcw, input logic [1:0] pcs, input logic bs,
                               input logic [2:0] alu, input logic rw, input logic [1:0] wb,
                               input logic fw, ow, il);
    vec_t v;
    v.name = nm; v.ops = ops; v.z = z; v.c = c; v.pc_we = pcw; v.pc_sel = pcs;
    v.b_sel = bs; v.alu = alu; v.reg_we = rw; v.wb = wb; v.flag_we = fw;
    v.out_we = ow; v.ill = il;
    return v;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.st = state; o.mem_req = mem_req; o.mem_we = mem_we; o.addr_sel = addr_sel;
    o.ir_we = ir_we; o.pc_we = pc_we; o.pc_sel = pc_sel; o.b_sel = b_sel;
    o.alu_op = alu_op; o.reg_we = reg_we; o.wb_sel = wb_sel; o.flag_we = flag_we;
    o.out_we = out_we; o.illegal_op = illegal_op; o.halted = halted; o.fault = fault;
    o.cnt = inst_count;
    return o;
  endfunction

  task automatic check_head();
    obs_t  a, e;
    string nm;
    a  = sample();
    e  = exp_q.pop_front();
    nm = name_q.pop_front();
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", nm, a, e);
    end
  endtask

  // Inputs are set at the falling edge; outputs are checked 1 ns later.
  task automatic expect_cyc(input string nm, input obs_t e);
    exp_q.push_back(e);
    name_q.push_back(nm);
    #1;
    check_head();
    @(negedge clk);
  endtask

  task automatic run_fetch(input string nm, input int waits);
    obs_t e;
    for (int k = 0; k < waits; k++) begin
      mem_ready = 1'b0;
      e = idle(3'd0); e.mem_req = 1'b1;
      expect_cyc({nm, " fetch-wait"}, e);
    end
    mem_ready = 1'b1;
    e = idle(3'd0); e.mem_req = 1'b1; e.ir_we = 1'b1; e.pc_we = 1'b1;
    expect_cyc({nm, " fetch"}, e);
    expect_cyc({nm, " decode"}, idle(3'd1));
  endtask

  task automatic run_vec(input vec_t v);
    obs_t e;
    dec_ops = v.ops; flag_z = v.z; flag_c = v.c;
    run_fetch(v.name, 0);
    e = idle(3'd2);
    e.pc_we = v.pc_we; e.pc_sel = v.pc_sel; e.b_sel = v.b_sel; e.alu_op = v.alu;
    e.reg_we = v.reg_we; e.wb_sel = v.wb; e.flag_we = v.flag_we; e.out_we = v.out_we;
    e.illegal_op = v.ill;
    expect_cyc({v.name, " exec"}, e);
    cnt_m++;
  endtask

  task automatic do_reset(input logic [2:0] cur_st);
    rst = 1'b1;
    expect_cyc("reset-assert", idle(cur_st));
    cnt_m = 16'd0;
    expect_cyc("reset-held", idle(3'd0));
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    obs_t e;
    //                name      ops            z  c  pcw sel bs alu rw wb  fw ow il
    tbl.push_back(mkv("ADD",    op(7),         0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0));
    tbl.push_back(mkv("ADC",    op(8),         0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0));
    tbl.push_back(mkv("SUB",    op(9),         0, 0, 0, 0, 0, 2, 1, 0, 1, 0, 0));
    tbl.push_back(mkv("SBB",    op(10),        0, 0, 0, 0, 0, 3, 1, 0, 1, 0, 0));
    tbl.push_back(mkv("ADDI",   op(1),         0, 0, 0, 0, 1, 0, 1, 0, 1, 0, 0));
    tbl.push_back(mkv("SUBI",   op(2),         0, 0, 0, 0, 1, 2, 1, 0, 1, 0, 0));
    tbl.push_back(mkv("CMP",    op(11),        0, 0, 0, 0, 0, 2, 0, 0, 1, 0, 0));
    tbl.push_back(mkv("MOV",    op(0),         0, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0));
    tbl.push_back(mkv("LHI",    op(3),         0, 0, 0, 0, 1, 5, 1, 0, 0, 0, 0));
    tbl.push_back(mkv("LLI",    op(4),         0, 0, 0, 0, 1, 6, 1, 0, 0, 0, 0));
    tbl.push_back(mkv("BCC-t",  op(12),        1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mkv("BCC-n",  op(12),        0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mkv("BCS-t",  op(13),        0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mkv("BCS-n",  op(13),        1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mkv("BNE-t",  op(14),        0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mkv("BNE-n",  op(14),        1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mkv("BEQ-n",  op(15),        0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mkv("BEQ-t",  op(15),        1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mkv("BAL",    op(16),        0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mkv("JMP",    op(17),        0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mkv("JALL",   op(18),        0, 0, 1, 1, 0, 0, 1, 2, 0, 0, 0));
    tbl.push_back(mkv("JALR",   op(19),        0, 0, 1, 2, 0, 0, 1, 2, 0, 0, 0));
    tbl.push_back(mkv("JR",     op(20),        0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mkv("OUTR",   op(21),        0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mkv("ILL-0",  23'h000000,    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mkv("ILL-3",  23'h000003,    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mkv("ILL-hi", 23'h600000,    1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1));

    rst = 1'b1; dec_ops = '0; flag_z = 1'b0; flag_c = 1'b0; mem_ready = 1'b0;
    cnt_m = 16'd0;
    @(negedge clk);
    expect_cyc("reset", idle(3'd0));
    rst = 1'b0;

    foreach (tbl[i]) run_vec(tbl[i]);

    // LDR: ready arrives on the 4th MEM cycle, which is exactly the timeout limit.
    dec_ops = op(5);
    run_fetch("LDR", 0);
    mem_ready = 1'b0;
    e = idle(3'd2); e.b_sel = 1'b1;
    expect_cyc("LDR exec", e);
    for (int k = 0; k < 3; k++) begin
      e = idle(3'd3); e.mem_req = 1'b1; e.addr_sel = 1'b1; e.b_sel = 1'b1;
      expect_cyc("LDR mem-wait", e);
    end
    mem_ready = 1'b1;
    e = idle(3'd3); e.mem_req = 1'b1; e.addr_sel = 1'b1; e.b_sel = 1'b1;
    e.reg_we = 1'b1; e.wb_sel = 2'd1;
    expect_cyc("LDR mem-ready", e);
    cnt_m++;

    dec_ops = op(6);
    run_fetch("STR", 0);
    e = idle(3'd2); e.b_sel = 1'b1;
    expect_cyc("STR exec", e);
    e = idle(3'd3); e.mem_req = 1'b1; e.addr_sel = 1'b1; e.b_sel = 1'b1; e.mem_we = 1'b1;
    expect_cyc("STR mem", e);
    cnt_m++;

    // FETCH ready on the last allowed cycle is accepted.
    dec_ops = op(0);
    run_fetch("MOV-late", 3);
    e = idle(3'd2); e.alu_op = 3'd4; e.reg_we = 1'b1;
    expect_cyc("MOV-late exec", e);
    cnt_m++;

    // Reset while a load waits in MEM: no retire, counter cleared.
    dec_ops = op(5);
    run_fetch("LDR-abort", 0);
    mem_ready = 1'b0;
    e = idle(3'd2); e.b_sel = 1'b1;
    expect_cyc("LDR-abort exec", e);
    e = idle(3'd3); e.mem_req = 1'b1; e.addr_sel = 1'b1; e.b_sel = 1'b1;
    expect_cyc("LDR-abort mem", e);
    do_reset(3'd3);

    run_vec(tbl[0]);
    dec_ops = op(22);
    run_fetch("HLT", 0);
    expect_cyc("HLT exec", idle(3'd2));
    cnt_m++;
    for (int k = 0; k < 4; k++) begin
      mem_ready = k[0];
      e = idle(3'd4); e.halted = 1'b1;
      expect_cyc("HALT hold", e);
    end
    do_reset(3'd4);

    // Memory never answers: four FETCH request cycles, then FAULT.
    dec_ops = op(7);
    mem_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      e = idle(3'd0); e.mem_req = 1'b1;
      expect_cyc("timeout fetch", e);
    end
    for (int k = 0; k < 3; k++) begin
      mem_ready = k[0];
      e = idle(3'd5); e.halted = 1'b1; e.fault = 1'b1;
      expect_cyc("FAULT hold", e);
    end
    do_reset(3'd5);
    run_vec(tbl[1]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
